// File: rtl/minicpu_pkg.sv
// Shared types and constants for the minicpu front end.
package minicpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fs_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hffff_fffc;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// FIFO of fetched {pc,inst} entries between the SRAM response and decode.
module if_fifo
    import minicpu_pkg::*;
#(
    parameter  int BUF_DEPTH = 2,
    localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush_i,
    input  logic             push_i,
    input  fs_entry_t        push_data_i,
    input  logic             pop_i,
    output fs_entry_t        head_o,
    output logic [CNT_W-1:0] count_o
);

    fs_entry_t        mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop_s;
    logic             do_push_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return PTR_W'(0);
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_pop_s  = pop_i & (count_q != CNT_W'(0));
    assign do_push_s = push_i & ((count_q != CNT_W'(BUF_DEPTH)) | do_pop_s);

    // Pointer and occupancy next-state; flush empties the buffer outright.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = PTR_W'(0);
            wr_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= PTR_W'(0);
            wr_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '{pc: 32'h0000_0000, inst: 32'h0000_0000};
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push_s && !flush_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end else begin
                mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: BOOT/RUN sequencing, fetch pc, redirect/cancel, output buffer.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage
    import minicpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_en,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fs_state_e        state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;

    logic             run_s;
    logic             flush_s;
    logic             pop_s;
    logic             push_s;
    logic             req_s;
    logic [31:0]      req_addr_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [CNT_W:0]   occ_s;
    fs_entry_t        head_s;
    fs_entry_t        push_data_s;

    assign run_s   = (state_q == ST_RUN);
    assign flush_s = br_taken & run_s;

    // A redirect hides the head for the cycle, so no pop can slip past a flush.
    assign fs_to_ds_valid = (fifo_count_s != CNT_W'(0)) & ~flush_s;
    assign pop_s          = fs_to_ds_valid & ds_allowin;
    assign push_s         = inflight_q & ~flush_s;
    assign occ_s          = {1'b0, fifo_count_s} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop_s);

    // BOOT lasts a single cycle, then fetching runs until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // Request issue, fetch pc advance and in-flight tracking.
    always_comb begin
        req_s         = 1'b0;
        req_addr_s    = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (!run_s) begin
            req_s = 1'b0;
        end else if (flush_s) begin
            req_s      = 1'b1;
            req_addr_s = word_align(br_target);
        end else if (occ_s < (CNT_W + 1)'(BUF_DEPTH)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        if (req_s) begin
            fetch_pc_d    = req_addr_s + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = req_addr_s;
        end else begin
            fetch_pc_d    = fetch_pc_q;
            inflight_d    = 1'b0;
            inflight_pc_d = inflight_pc_q;
        end
    end

    // State, fetch pc and in-flight request registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_BOOT;
            fetch_pc_q    <= word_align(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign push_data_s = '{pc: inflight_pc_q, inst: inst_sram_rdata};

    if_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .flush_i     (flush_s),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (fifo_count_s)
    );

    assign inst_sram_en    = req_s;
    assign inst_sram_we    = 1'b0;
    assign inst_sram_addr  = req_addr_s;
    assign inst_sram_wdata = 32'h0000_0000;
    assign fs_pc           = head_s.pc;
    assign fs_inst         = head_s.inst;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [15:0] perf_flush_q;

    // Delivered-instruction count wraps; redirect count saturates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetch_q <= 32'h0000_0000;
            perf_flush_q <= 16'h0000;
        end else begin
            if (pop_s) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end else begin
                perf_fetch_q <= perf_fetch_q;
            end
            if (flush_s && (perf_flush_q != 16'hffff)) begin
                perf_flush_q <= perf_flush_q + 16'd1;
            end else begin
                perf_flush_q <= perf_flush_q;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
